// File: rtl/rx_req_parser_pkg.sv
// Shared types and constants for the TRN receive request parser.
// Holds FSM states, header bundle, command-word field positions and the command builder.
package rx_req_parser_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR2    = 2'd1,
      PUSH    = 2'd2,
      DISCARD = 2'd3
   } state_e;

   localparam logic [1:0] US_CMD_CPL_TYPE  = 2'b01;
   localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;

   localparam logic [6:0] MRD32 = 7'h00;
   localparam logic [6:0] MWR32 = 7'h40;

   localparam int CMD_ADDR    = 0;
   localparam int CMD_BE      = 6;
   localparam int CMD_TAG     = 14;
   localparam int CMD_RID     = 22;
   localparam int CMD_LEN     = 38;
   localparam int CMD_ATTR    = 48;
   localparam int CMD_EP      = 50;
   localparam int CMD_TD      = 51;
   localparam int CMD_TC      = 52;
   localparam int CMD_TYPE    = 62;
   localparam int CMD_ADDR_HI = 64;
   localparam int CMD_STAT    = 125;

   typedef struct packed {
      logic [2:0]  tc;
      logic        td;
      logic        ep;
      logic [1:0]  attr;
      logic [9:0]  len;
      logic [15:0] rid;
      logic [7:0]  tag;
      logic [7:0]  be;
   } hdr_t;

   // ur selects an unsupported-request completion instead of a read completion
   function automatic logic [127:0] make_cmd(
      input hdr_t        h,
      input logic [29:0] a,
      input logic        ur,
      input logic [5:0]  mask
   );
      logic [127:0] c;
      c = '0;
      c[CMD_TYPE +: 2]     = ur ? US_CMD_CPL_TYPE : US_CMD_CPLD_TYPE;
      c[CMD_STAT +: 3]     = ur ? 3'b001 : 3'b000;
      c[CMD_TC +: 3]       = h.tc;
      c[CMD_TD]            = h.td;
      c[CMD_EP]            = h.ep;
      c[CMD_ATTR +: 2]     = h.attr;
      c[CMD_LEN +: 10]     = h.len;
      c[CMD_RID +: 16]     = h.rid;
      c[CMD_TAG +: 8]      = h.tag;
      c[CMD_BE +: 8]       = h.be;
      c[CMD_ADDR +: 6]     = a[5:0] & mask;
      c[CMD_ADDR_HI +: 32] = {2'b00, a};
      return c;
   endfunction

endpackage

// File: rtl/rx_req_parser_if.sv
// TRN receive bundle between the PCIe endpoint (master) and the parser (slave).
// Carries data, remainder, framing, discontinue, BAR hit and the sink-ready return.
interface rx_req_parser_if;
   logic [63:0] trn_rd;
   logic [7:0]  trn_rrem_n;
   logic        trn_rsof_n;
   logic        trn_reof_n;
   logic        trn_rsrc_rdy_n;
   logic        trn_rsrc_dsc_n;
   logic [6:0]  trn_rbar_hit_n;
   logic        trn_rdst_rdy_n;

   modport master (
      output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
      output trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
      input  trn_rdst_rdy_n
   );

   modport slave (
      input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
      input  trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
      output trn_rdst_rdy_n
   );
endinterface

// File: rtl/rx_req_parser.sv
// Decodes 1-DW MRd32/MWr32 TLPs from TRN: reads -> 128-bit FIFO command, writes -> reg strobe.
// Ports: clk, rst_n (sync, active-low), trn (TRN rx slave), us_cmd_fifo_*, reg_wr_*, drop_cnt_o.
// Option: define RX_UR_CPL_EN to emit UR completions for dropped non-posted requests.
module rx_req_parser
   import rx_req_parser_pkg::*;
#(
   parameter int BAR_INDEX    = 0,
   parameter int ADDR_DW_BITS = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rx_req_parser_if.slave          trn,
   input  logic                    us_cmd_fifo_full_i,
   output logic                    us_cmd_fifo_wr_en_o,
   output logic [127:0]            us_cmd_fifo_din_o,
   output logic                    reg_wr_en_o,
   output logic [ADDR_DW_BITS-1:0] reg_wr_addr_o,
   output logic [31:0]             reg_wr_data_o,
   output logic [3:0]              reg_wr_be_o,
   output logic [15:0]             drop_cnt_o
);

`ifdef RX_UR_CPL_EN
   localparam bit UrEn = 1'b1;
`else
   localparam bit UrEn = 1'b0;
`endif

   localparam logic [5:0] DwMask = 6'((7'd1 << ADDR_DW_BITS) - 7'd1);

   state_e      state_q, state_d;
   hdr_t        hdr_q, hdr_d, sof_hdr;
   logic        is_wr_q, is_wr_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        tally_q, tally_d;
   logic        ur_q, ur_d;
   logic        wr_en_q, wr_en_d;
   logic [15:0] cnt_q, cnt_d;
   logic        rdy_n, push, drop;
   logic        src, sof, eof, dsc, qual;
   logic [6:0]  ft;
   logic        rrem_unused;

   assign src = !trn.trn_rsrc_rdy_n;
   assign sof = !trn.trn_rsof_n;
   assign eof = !trn.trn_reof_n;
   assign dsc = !trn.trn_rsrc_dsc_n;
   assign ft  = trn.trn_rd[62:56];
   assign rrem_unused = ^trn.trn_rrem_n;

   assign qual = (ft == MRD32 || ft == MWR32)
              && trn.trn_rd[41:32] == 10'd1
              && !trn.trn_rbar_hit_n[BAR_INDEX];

   always_comb begin
      sof_hdr.tc   = trn.trn_rd[54:52];
      sof_hdr.td   = trn.trn_rd[47];
      sof_hdr.ep   = trn.trn_rd[46];
      sof_hdr.attr = trn.trn_rd[45:44];
      sof_hdr.len  = trn.trn_rd[41:32];
      sof_hdr.rid  = trn.trn_rd[31:16];
      sof_hdr.tag  = trn.trn_rd[15:8];
      sof_hdr.be   = trn.trn_rd[7:0];
   end

   // tally_q marks a TLP whose loss must be counted; reset tails are not
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tally_d = tally_q;
      ur_d    = ur_q;
      wr_en_d = 1'b0;
      rdy_n   = 1'b1;
      push    = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            rdy_n = us_cmd_fifo_full_i;
            if (src && !us_cmd_fifo_full_i) begin
               if (sof) begin
                  hdr_d   = sof_hdr;
                  is_wr_d = (ft == MWR32);
                  tally_d = 1'b1;
                  ur_d    = 1'b0;
                  if (qual) begin
                     state_d = HDR2;
                  end else begin
                     ur_d = UrEn && !trn.trn_rd[62];
                     if (eof) begin
                        drop = 1'b1;
                        if (ur_d) begin
                           state_d = PUSH;
                           tally_d = 1'b0;
                        end
                     end else begin
                        state_d = DISCARD;
                     end
                  end
               end else begin
                  tally_d = 1'b0;
                  ur_d    = 1'b0;
                  if (!eof) state_d = DISCARD;
               end
            end
         end
         HDR2: begin
            rdy_n = 1'b0;
            if (src) begin
               addr_d = trn.trn_rd[63:34];
               if (is_wr_q) data_d = trn.trn_rd[31:0];
               if (!eof) begin
                  state_d = DISCARD;
               end else if (is_wr_q) begin
                  wr_en_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = PUSH;
               end
            end
         end
         PUSH: begin
            if (!us_cmd_fifo_full_i) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         DISCARD: begin
            rdy_n = 1'b0;
            if (src && eof) begin
               drop = tally_q;
               if (tally_q && ur_q) begin
                  state_d = PUSH;
                  tally_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (dsc && state_q != IDLE) begin
         state_d = IDLE;
         wr_en_d = 1'b0;
         push    = 1'b0;
         ur_d    = 1'b0;
         drop    = tally_q;
      end
      cnt_d = cnt_q;
      if (drop && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hdr_q   <= '0;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         tally_q <= 1'b0;
         ur_q    <= 1'b0;
         wr_en_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tally_q <= tally_d;
         ur_q    <= ur_d;
         wr_en_q <= wr_en_d;
         cnt_q   <= cnt_d;
      end
   end

   assign trn.trn_rdst_rdy_n = !rst_n || rdy_n;
   assign us_cmd_fifo_wr_en_o = rst_n && push;
   assign us_cmd_fifo_din_o   = (rst_n && push) ? make_cmd(hdr_q, addr_q, ur_q, DwMask) : '0;
   assign reg_wr_en_o   = wr_en_q;
   assign reg_wr_addr_o = addr_q[ADDR_DW_BITS-1:0];
   assign reg_wr_data_o = data_q;
   assign reg_wr_be_o   = hdr_q.be[3:0];
   assign drop_cnt_o    = cnt_q;

endmodule

// File: tb/tb_rx_req_parser.sv
// Self-checking bench for rx_req_parser: table of TLP vectors plus hand sequences
// for FIFO back-pressure, discontinue, mid-TLP reset and drop-counter saturation.
module tb_rx_req_parser;
   import rx_req_parser_pkg::*;

`ifdef RX_UR_CPL_EN
   localparam bit UR = 1'b1;
`else
   localparam bit UR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         full = 1'b0;
   logic         wr_en;
   logic [127:0] din;
   logic         reg_en;
   logic [5:0]   reg_addr;
   logic [31:0]  reg_data;
   logic [3:0]   reg_be;
   logic [15:0]  drop_o;

   always #5 clk = ~clk;

   rx_req_parser_if trn_if();

   rx_req_parser #(.BAR_INDEX(0), .ADDR_DW_BITS(6)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .trn                 (trn_if),
      .us_cmd_fifo_full_i  (full),
      .us_cmd_fifo_wr_en_o (wr_en),
      .us_cmd_fifo_din_o   (din),
      .reg_wr_en_o         (reg_en),
      .reg_wr_addr_o       (reg_addr),
      .reg_wr_data_o       (reg_data),
      .reg_wr_be_o         (reg_be),
      .drop_cnt_o          (drop_o)
   );

   typedef struct {
      logic [6:0]  ft;
      logic [9:0]  len;
      logic [2:0]  tc;
      logic [1:0]  attr;
      logic [6:0]  bar;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  tag;
      logic [15:0] rid;
      logic [7:0]  be;
      int          nb;
      bit          push;
      bit          ur;
      bit          wr;
      bit          drop;
   } tlp_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int eof_cyc = 0;
   int push_n = 0;
   int push_cyc = 0;
   int regw_n = 0;
   int regw_cyc = 0;
   logic [127:0] push_din;
   logic [5:0]   w_addr;
   logic [31:0]  w_data;
   logic [3:0]   w_be;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wr_en) begin
         push_n   = push_n + 1;
         push_cyc = cyc;
         push_din = din;
      end
      if (reg_en) begin
         regw_n   = regw_n + 1;
         regw_cyc = cyc;
         w_addr   = reg_addr;
         w_data   = reg_data;
         w_be     = reg_be;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      trn_if.trn_rd         = '0;
      trn_if.trn_rrem_n     = 8'h00;
      trn_if.trn_rsof_n     = 1'b1;
      trn_if.trn_reof_n     = 1'b1;
      trn_if.trn_rsrc_rdy_n = 1'b1;
      trn_if.trn_rsrc_dsc_n = 1'b1;
      trn_if.trn_rbar_hit_n = 7'h7F;
   endtask

   task automatic drive(input logic [63:0] d, input bit sof, input bit eof,
                        input logic [6:0] bar, input bit dsc);
      trn_if.trn_rd         = d;
      trn_if.trn_rrem_n     = 8'h00;
      trn_if.trn_rsof_n     = !sof;
      trn_if.trn_reof_n     = !eof;
      trn_if.trn_rbar_hit_n = bar;
      trn_if.trn_rsrc_dsc_n = !dsc;
      trn_if.trn_rsrc_rdy_n = 1'b0;
   endtask

   // called just after a rising edge; returns just after the accepting edge
   task automatic beat(input logic [63:0] d, input bit sof, input bit eof,
                       input logic [6:0] bar, input bit dsc);
      int n;
      drive(d, sof, eof, bar, dsc);
      n = 0;
      @(negedge clk);
      while (trn_if.trn_rdst_rdy_n && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL beat_accept: rdst_rdy_n stuck at 1, want 0 within 40 cycles");
      end
      @(posedge clk);
      #1;
      eof_cyc = cyc;
      idle_in();
   endtask

   function automatic logic [63:0] hdr_beat(input tlp_t t);
      return {1'b0, t.ft, 1'b0, t.tc, 4'b0, 2'b00, t.attr, 2'b00, t.len,
              t.rid, t.tag, t.be};
   endfunction

   function automatic logic [63:0] addr_beat(input tlp_t t);
      return {t.addr[31:2], 2'b00, t.data};
   endfunction

   task automatic send(input tlp_t t);
      if (t.nb == 1) begin
         beat(hdr_beat(t), 1'b1, 1'b1, t.bar, 1'b0);
      end else begin
         beat(hdr_beat(t), 1'b1, 1'b0, t.bar, 1'b0);
         for (int k = 1; k < t.nb; k++)
            beat(addr_beat(t), 1'b0, k == t.nb - 1, t.bar, 1'b0);
      end
   endtask

   function automatic logic [127:0] exp_din(input tlp_t t, input bit ur);
      logic [127:0] c;
      c = '0;
      c[63:62] = ur ? 2'b01 : 2'b10;
      if (ur) c[127:125] = 3'b001;
      c[54:52] = t.tc;
      c[49:48] = t.attr;
      c[47:38] = t.len;
      c[37:22] = t.rid;
      c[21:14] = t.tag;
      c[13:6]  = t.be;
      c[5:0]   = t.addr[7:2];
      c[95:64] = {2'b00, t.addr[31:2]};
      return c;
   endfunction

   // address, BE and TD/EP are not defined for UR completions
   function automatic logic [127:0] din_mask(input bit ur);
      return ur ? {32'hFFFF_FFFF, 32'h0, 9'h1FF, 3'h7, 2'b00, 2'b11,
                   34'h3_FFFF_FFFF, 14'h0}
                : {128{1'b1}};
   endfunction

   task automatic run_vec(input tlp_t t, input string nm);
      int p0, r0;
      logic [15:0] d0, dd;
      bit ep, ur;
      p0 = push_n;
      r0 = regw_n;
      d0 = drop_o;
      send(t);
      repeat (4) @(posedge clk);
      #1;
      ur = UR && t.ur;
      ep = t.push || ur;
      dd = drop_o - d0;
      chk({nm, "_push"}, push_n - p0, longint'(ep));
      chk({nm, "_regw"}, regw_n - r0, longint'(t.wr));
      chk({nm, "_drop"}, dd, longint'(t.drop));
      if (ep) begin
         chk({nm, "_push_lat"}, push_cyc - eof_cyc, 1);
         chk_w({nm, "_din"}, push_din & din_mask(ur), exp_din(t, ur) & din_mask(ur));
      end
      if (t.wr) begin
         chk({nm, "_wr_lat"}, regw_cyc - eof_cyc, 1);
         chk({nm, "_wr_addr"}, w_addr, t.addr[7:2]);
         chk({nm, "_wr_data"}, w_data, t.data);
         chk({nm, "_wr_be"}, w_be, t.be[3:0]);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   tlp_t v[10];
   tlp_t mrd, mwr, bad64;
   int p0, r0;

   initial begin
      v[0] = '{7'h00, 10'd1, 3'd0, 2'd0, 7'h7E, 32'h0000_0014, 32'h0,
               8'h5A, 16'h0100, 8'h0F, 2, 1'b1, 1'b0, 1'b0, 1'b0};
      v[1] = '{7'h40, 10'd1, 3'd0, 2'd0, 7'h7E, 32'h0000_0008, 32'hDEAD_BEEF,
               8'h01, 16'h0100, 8'h0F, 2, 1'b0, 1'b0, 1'b1, 1'b0};
      v[2] = '{7'h00, 10'd1, 3'd5, 2'd2, 7'h7E, 32'hABCD_00FC, 32'h0,
               8'h33, 16'hABCD, 8'h03, 2, 1'b1, 1'b0, 1'b0, 1'b0};
      v[3] = '{7'h40, 10'd1, 3'd0, 2'd1, 7'h7E, 32'h0000_01FC, 32'h1234_5678,
               8'h02, 16'h0200, 8'h06, 2, 1'b0, 1'b0, 1'b1, 1'b0};
      v[4] = '{7'h00, 10'd2, 3'd0, 2'd0, 7'h7E, 32'h0000_0020, 32'h0,
               8'h44, 16'h0100, 8'hFF, 2, 1'b0, 1'b1, 1'b0, 1'b1};
      v[5] = '{7'h00, 10'd1, 3'd0, 2'd0, 7'h7D, 32'h0000_0020, 32'h0,
               8'h45, 16'h0100, 8'h0F, 2, 1'b0, 1'b1, 1'b0, 1'b1};
      v[6] = '{7'h60, 10'd1, 3'd0, 2'd0, 7'h7E, 32'h0000_0020, 32'hCAFE_F00D,
               8'h46, 16'h0100, 8'h0F, 3, 1'b0, 1'b0, 1'b0, 1'b1};
      v[7] = '{7'h40, 10'd1, 3'd0, 2'd0, 7'h7D, 32'h0000_0020, 32'h1,
               8'h47, 16'h0100, 8'h0F, 2, 1'b0, 1'b0, 1'b0, 1'b1};
      v[8] = '{7'h20, 10'd1, 3'd3, 2'd0, 7'h7E, 32'h0000_0040, 32'h0,
               8'h11, 16'h0300, 8'h0F, 2, 1'b0, 1'b1, 1'b0, 1'b1};
      v[9] = '{7'h00, 10'd1, 3'd7, 2'd3, 7'h00, 32'hFFFF_FFFC, 32'h0,
               8'hFF, 16'hFFFF, 8'hFF, 2, 1'b1, 1'b0, 1'b0, 1'b0};
      mrd   = v[0];
      mwr   = v[1];
      bad64 = v[6];

      idle_in();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy_n", trn_if.trn_rdst_rdy_n, 1);
      chk("rst_wr_en", wr_en, 0);
      chk_w("rst_din", din, '0);
      chk("rst_reg_en", reg_en, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_data", reg_data, 0);
      chk("rst_reg_be", reg_be, 0);
      chk("rst_drop", drop_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_rdy_n", trn_if.trn_rdst_rdy_n, 0);

      for (int i = 0; i < 10; i++)
         run_vec(v[i], $sformatf("v%0d", i));

      // FIFO full in IDLE: SOF must not be taken
      do_reset();
      full = 1'b1;
      #1;
      drive(hdr_beat(mwr), 1'b1, 1'b0, 7'h7E, 1'b0);
      repeat (3) @(negedge clk);
      chk("full_idle_rdy_n", trn_if.trn_rdst_rdy_n, 1);
      @(posedge clk);
      #1;
      full = 1'b0;
      run_vec(mwr, "full_idle_mwr");

      // FIFO full raised while the command waits in PUSH
      p0 = push_n;
      beat(hdr_beat(mrd), 1'b1, 1'b0, 7'h7E, 1'b0);
      full = 1'b1;
      beat(addr_beat(mrd), 1'b0, 1'b1, 7'h7E, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("push_held", push_n - p0, 0);
      chk("push_busy_rdy_n", trn_if.trn_rdst_rdy_n, 1);
      full = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("push_released", push_n - p0, 1);
      chk_w("push_released_din", push_din, exp_din(mrd, 1'b0));

      // source discontinue during HDR2
      p0 = push_n;
      r0 = regw_n;
      chk("dsc_drop_before", drop_o, 0);
      beat(hdr_beat(mrd), 1'b1, 1'b0, 7'h7E, 1'b0);
      beat(addr_beat(mrd), 1'b0, 1'b1, 7'h7E, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("dsc_push", push_n - p0, 0);
      chk("dsc_regw", regw_n - r0, 0);
      chk("dsc_drop", drop_o, 1);
      run_vec(mwr, "dsc_after_mwr");

      // reset mid-TLP: tail beats sunk without counting
      beat(hdr_beat(mrd), 1'b1, 1'b0, 7'h7E, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_rdy_n", trn_if.trn_rdst_rdy_n, 1);
      @(posedge clk);
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_reg_en", reg_en, 0);
      chk("midrst_drop", drop_o, 0);
      rst_n = 1'b1;
      p0 = push_n;
      r0 = regw_n;
      beat(addr_beat(mrd), 1'b0, 1'b0, 7'h7E, 1'b0);
      beat(addr_beat(mrd), 1'b0, 1'b1, 7'h7E, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("tail_push", push_n - p0, 0);
      chk("tail_regw", regw_n - r0, 0);
      chk("tail_drop", drop_o, 0);
      run_vec(mwr, "tail_after_mwr");

      // saturation: one single-beat bad TLP per cycle
      do_reset();
      drive(hdr_beat(bad64), 1'b1, 1'b1, 7'h7E, 1'b0);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", drop_o, 16'hFFFE);
      repeat (5) @(posedge clk);
      #1;
      idle_in();
      chk("sat_ffff", drop_o, 16'hFFFF);
      send(bad64);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", drop_o, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
